// File: rtl/spike_rate_decoder.sv
// Rate-coded spike decoder: counts spikes per neuron over a window of timesteps,
// then scans the counters to report the most active neuron (argmax) and whether it tied.
module spike_rate_decoder #(
  parameter int NUM_NEURONS = 10,
  parameter int COUNT_W     = 8,
  localparam int CLS_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [15:0]            window_len,
  input  logic                   step_en,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [CLS_W-1:0]       class_out,
  output logic [COUNT_W-1:0]     max_count,
  output logic                   tie,
  output logic [1:0]             dbg_state
);

  // Result handshake: result_valid rises on entry to DONE and stays high, with
  // class_out/max_count/tie stable, until a cycle where result_valid and
  // result_ready are both high; that cycle is the transfer.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CLS_W-1:0]   LAST_IDX = CLS_W'(NUM_NEURONS - 1);

  state_t             state, state_nxt;
  logic [COUNT_W-1:0] cnt [NUM_NEURONS];
  logic [15:0]        step_cnt;
  logic [15:0]        win_len;
  logic [CLS_W-1:0]   scan_idx;
  logic [COUNT_W-1:0] scan_val;
  logic               last_step;

  assign last_step = (step_cnt == (win_len - 16'd1));
  assign scan_val  = cnt[scan_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (window_len == 16'd0) ? SCAN : ACCUM;
        end
      end
      ACCUM: begin
        if (step_en && last_step) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (scan_idx == LAST_IDX) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt[i] <= '0;
      end
      step_cnt  <= '0;
      win_len   <= '0;
      scan_idx  <= '0;
      class_out <= '0;
      max_count <= '0;
      tie       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
              cnt[i] <= '0;
            end
            step_cnt <= '0;
            win_len  <= window_len;
            scan_idx <= '0;
          end
        end
        ACCUM: begin
          if (step_en) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
              if (spikes_in[i] && (cnt[i] != CNT_MAX)) begin
                cnt[i] <= cnt[i] + COUNT_W'(1);
              end
            end
            step_cnt <= step_cnt + 16'd1;
          end
        end
        SCAN: begin
          // Strict greater-than keeps the lowest index among equal counts.
          if (scan_idx == '0) begin
            class_out <= '0;
            max_count <= scan_val;
            tie       <= 1'b0;
          end else if (scan_val > max_count) begin
            class_out <= scan_idx;
            max_count <= scan_val;
            tie       <= 1'b0;
          end else if (scan_val == max_count) begin
            tie <= 1'b1;
          end
          scan_idx <= scan_idx + CLS_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign busy         = (state == ACCUM) || (state == SCAN);
  assign result_valid = (state == DONE);
  assign dbg_state    = state;

endmodule
